// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI minion: FSM state, per-frame mode
// and the decode of which sclk edge captures mosi.
package spi_pkg;

   localparam int DEFAULT_SYNC_STAGES = 2;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } spi_state_t;

   typedef struct packed {
      logic cpol;
      logic cpha;
   } spi_mode_t;

   // Leading edge is the edge leaving the idle level; CPHA=0 samples on it,
   // CPHA=1 samples on the trailing edge.
   function automatic logic sample_edge(input spi_mode_t mode, input logic rise,
                                        input logic fall);
      logic leading;
      logic trailing;
      leading  = mode.cpol ? fall : rise;
      trailing = mode.cpol ? rise : fall;
      return mode.cpha ? trailing : leading;
   endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous pin plus rise/fall detection
// on the synchronised value.
module spi_sync_edge
   import spi_pkg::*;
#(
   parameter int   SYNC_STAGES = DEFAULT_SYNC_STAGES,
   parameter logic RESET_VAL   = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic d_i,
   output logic q_o,
   output logic rise_o,
   output logic fall_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   // Shift the pin through the chain and remember the previous synchronised sample.
   always_ff @(posedge clk) begin
      // NOTE: state is updated with <= only, so every flop sees the pre-edge values.
      if (!reset) begin
         sync_q <= {SYNC_STAGES{RESET_VAL}};
         prev_q <= RESET_VAL;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign q_o    = sync_q[SYNC_STAGES-1];
   assign rise_o = q_o & ~prev_q;
   assign fall_o = ~q_o & prev_q;

endmodule

// File: rtl/spi_minion_mode.sv
// SPI minion supporting all four modes, with a one-entry transmit buffer,
// frame-length checking, overflow/underrun flags and receive parity.
module spi_minion_mode
   import spi_pkg::*;
#(
   parameter int BIT_WIDTH    = 32,
   parameter int SYNC_STAGES  = DEFAULT_SYNC_STAGES,
   parameter int PARITY_WIDTH = BIT_WIDTH - 3
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 cs,
   input  logic                 sclk,
   input  logic                 mosi,
   output logic                 miso,
   input  logic                 cpol,
   input  logic                 cpha,
   input  logic [BIT_WIDTH-1:0] recv_msg,
   input  logic                 recv_val,
   output logic                 recv_rdy,
   output logic [BIT_WIDTH-1:0] send_msg,
   output logic                 send_val,
   input  logic                 send_rdy,
   output logic                 parity,
   output logic                 frame_err,
   output logic                 overflow,
   output logic                 underrun
);

   localparam int             CW         = $clog2(BIT_WIDTH + 1);
   localparam logic [CW-1:0]  FULL_COUNT = CW'(BIT_WIDTH);

   if (BIT_WIDTH < 8 || (BIT_WIDTH % 8) != 0) begin : g_bad_width
      $error("spi_minion_mode: BIT_WIDTH must be a multiple of 8 and >= 8");
   end
   if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("spi_minion_mode: SYNC_STAGES must be >= 2");
   end
   if (PARITY_WIDTH < 1 || PARITY_WIDTH > BIT_WIDTH) begin : g_bad_parity
      $error("spi_minion_mode: PARITY_WIDTH must be within 1..BIT_WIDTH");
   end

   logic cs_rise, cs_fall, sclk_rise, sclk_fall, mosi_sync;
   logic unused_cs_lvl, unused_sclk_lvl, unused_mosi_rise, unused_mosi_fall;

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
      .clk(clk), .reset(reset), .d_i(cs),
      .q_o(unused_cs_lvl), .rise_o(cs_rise), .fall_o(cs_fall)
   );
   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
      .clk(clk), .reset(reset), .d_i(sclk),
      .q_o(unused_sclk_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall)
   );
   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_mosi_sync (
      .clk(clk), .reset(reset), .d_i(mosi),
      .q_o(mosi_sync), .rise_o(unused_mosi_rise), .fall_o(unused_mosi_fall)
   );

   spi_state_t           state_q, state_d;
   spi_mode_t            mode_q, mode_d;
   logic [BIT_WIDTH-1:0] tx_buf_q, tx_buf_d;
   logic                 tx_full_q, tx_full_d;
   logic [BIT_WIDTH-1:0] tx_shift_q, tx_shift_d;
   logic [BIT_WIDTH-1:0] rx_shift_q, rx_shift_d;
   logic [CW-1:0]        count_q, count_d;
   logic                 over_q, over_d;
   logic                 skip_shift_q, skip_shift_d;
   logic                 miso_q, miso_d;
   logic [BIT_WIDTH-1:0] send_msg_q, send_msg_d;
   logic                 send_val_q, send_val_d;
   logic                 frame_err_q, frame_err_d;
   logic                 overflow_q, overflow_d;
   logic                 underrun_q, underrun_d;
   logic                 recv_rdy_q, recv_rdy_d;

   logic do_sample, do_shift;

   assign do_sample = sample_edge(mode_q, sclk_rise, sclk_fall);
   assign do_shift  = (sclk_rise | sclk_fall) & ~do_sample;

   // Next-state logic for the frame FSM, shifters and both handshakes.
   always_comb begin
      // NOTE: every _d starts from its _q (pulses from 0) so no path infers a latch.
      state_d      = state_q;
      mode_d       = mode_q;
      tx_buf_d     = tx_buf_q;
      tx_full_d    = tx_full_q;
      tx_shift_d   = tx_shift_q;
      rx_shift_d   = rx_shift_q;
      count_d      = count_q;
      over_d       = over_q;
      skip_shift_d = skip_shift_q;
      send_msg_d   = send_msg_q;
      send_val_d   = send_val_q;
      frame_err_d  = 1'b0;
      overflow_d   = 1'b0;
      underrun_d   = 1'b0;

      if (send_val_q && send_rdy) send_val_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (cs_fall) begin
               state_d      = ACTIVE;
               mode_d.cpol  = cpol;
               mode_d.cpha  = cpha;
               tx_shift_d   = tx_full_q ? tx_buf_q : '0;
               underrun_d   = ~tx_full_q;
               tx_full_d    = 1'b0;
               count_d      = '0;
               over_d       = 1'b0;
               skip_shift_d = cpha;
            end
         end
         ACTIVE: begin
            if (cs_rise) begin
               state_d = IDLE;
               if (count_q == FULL_COUNT && !over_q) begin
                  // A word still waiting on send_rdy is kept; the new one is lost.
                  if (!send_val_q || send_rdy) begin
                     send_msg_d = rx_shift_q;
                     send_val_d = 1'b1;
                  end else begin
                     overflow_d = 1'b1;
                  end
               end else begin
                  frame_err_d = 1'b1;
               end
            end else if (do_sample) begin
               if (count_q < FULL_COUNT) begin
                  rx_shift_d = {rx_shift_q[BIT_WIDTH-2:0], mosi_sync};
                  count_d    = count_q + CW'(1);
               end else begin
                  over_d = 1'b1;
               end
            end else if (do_shift) begin
               // With CPHA=1 the first leading edge precedes any sample, so the MSB must stay put.
               if (skip_shift_q) skip_shift_d = 1'b0;
               else              tx_shift_d   = {tx_shift_q[BIT_WIDTH-2:0], 1'b0};
            end
         end
         default: state_d = IDLE;
      endcase

      // A load in the cs-fall cycle lands in the buffer for the following frame.
      if (recv_val && recv_rdy_q) begin
         tx_buf_d  = recv_msg;
         tx_full_d = 1'b1;
      end

      miso_d     = (state_d == ACTIVE) ? tx_shift_d[BIT_WIDTH-1] : 1'b0;
      recv_rdy_d = (state_d == IDLE) && !tx_full_d;
   end

   // Register all state and outputs; reset aborts any frame silently.
   always_ff @(posedge clk) begin
      // NOTE: the data registers are reset too, since send_msg is visible and must read 0 after reset.
      if (!reset) begin
         state_q      <= IDLE;
         mode_q       <= '0;
         tx_buf_q     <= '0;
         tx_full_q    <= 1'b0;
         tx_shift_q   <= '0;
         rx_shift_q   <= '0;
         count_q      <= '0;
         over_q       <= 1'b0;
         skip_shift_q <= 1'b0;
         miso_q       <= 1'b0;
         send_msg_q   <= '0;
         send_val_q   <= 1'b0;
         frame_err_q  <= 1'b0;
         overflow_q   <= 1'b0;
         underrun_q   <= 1'b0;
         recv_rdy_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         mode_q       <= mode_d;
         tx_buf_q     <= tx_buf_d;
         tx_full_q    <= tx_full_d;
         tx_shift_q   <= tx_shift_d;
         rx_shift_q   <= rx_shift_d;
         count_q      <= count_d;
         over_q       <= over_d;
         skip_shift_q <= skip_shift_d;
         miso_q       <= miso_d;
         send_msg_q   <= send_msg_d;
         send_val_q   <= send_val_d;
         frame_err_q  <= frame_err_d;
         overflow_q   <= overflow_d;
         underrun_q   <= underrun_d;
         recv_rdy_q   <= recv_rdy_d;
      end
   end

   assign miso      = miso_q;
   assign recv_rdy  = recv_rdy_q;
   assign send_msg  = send_msg_q;
   assign send_val  = send_val_q;
   assign parity    = send_val_q & (^send_msg_q[PARITY_WIDTH-1:0]);
   assign frame_err = frame_err_q;
   assign overflow  = overflow_q;
   assign underrun  = underrun_q;

endmodule

// File: tb/tb_spi_minion_mode.sv
// Directed bench for spi_minion_mode: all four modes, short frame, overflow,
// underrun and reset in mid-frame.
module tb_spi_minion_mode;

   localparam int BW = 32;
   localparam int H  = 8;  // sclk half period in clk cycles

   logic          clk      = 1'b0;
   logic          reset    = 1'b0;
   logic          cs       = 1'b1;
   logic          sclk     = 1'b0;
   logic          mosi     = 1'b0;
   logic          cpol     = 1'b0;
   logic          cpha     = 1'b0;
   logic [BW-1:0] recv_msg = '0;
   logic          recv_val = 1'b0;
   logic          send_rdy = 1'b1;
   logic          miso, recv_rdy, send_val, parity, frame_err, overflow, underrun;
   logic [BW-1:0] send_msg;

   int checks = 0;
   int errors = 0;

   // Pulse and word monitor.
   int            fe_cnt = 0, ov_cnt = 0, ur_cnt = 0, sv_cnt = 0;
   logic [BW-1:0] last_msg = '0;
   logic          last_par = 1'b0;

   spi_minion_mode #(.BIT_WIDTH(BW), .SYNC_STAGES(2), .PARITY_WIDTH(BW - 3)) dut (
      .clk(clk), .reset(reset), .cs(cs), .sclk(sclk), .mosi(mosi), .miso(miso),
      .cpol(cpol), .cpha(cpha), .recv_msg(recv_msg), .recv_val(recv_val),
      .recv_rdy(recv_rdy), .send_msg(send_msg), .send_val(send_val),
      .send_rdy(send_rdy), .parity(parity), .frame_err(frame_err),
      .overflow(overflow), .underrun(underrun)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (frame_err) fe_cnt = fe_cnt + 1;
      if (overflow)  ov_cnt = ov_cnt + 1;
      if (underrun)  ur_cnt = ur_cnt + 1;
      if (send_val) begin
         sv_cnt   = sv_cnt + 1;
         last_msg = send_msg;
         last_par = parity;
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation still running at 2ms, expected to finish");
      $fatal(1, "watchdog expired");
   end

   task automatic wait_neg(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Offer a word on the transmit handshake, waiting a bounded time for recv_rdy.
   task automatic load_tx(input logic [BW-1:0] word);
      int n = 0;
      while (!recv_rdy && n < 100) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (recv_rdy !== 1'b1) begin
         errors++;
         $display("FAIL load_tx_rdy: recv_rdy=%b required 1 within 100 cycles", recv_rdy);
      end else begin
         recv_msg = word;
         recv_val = 1'b1;
         @(negedge clk);
         recv_val = 1'b0;
      end
   endtask

   // Master side of one frame; mode = {cpol, cpha}. Captures miso per bit.
   task automatic spi_frame(input logic [1:0] mode, input int nbits,
                            input logic [BW-1:0] din, input bit end_frame,
                            output logic [BW-1:0] dout);
      dout = '0;
      cpol = mode[1];
      cpha = mode[0];
      sclk = mode[1];
      wait_neg(H);
      cs = 1'b0;
      wait_neg(H);
      for (int i = 0; i < nbits; i++) begin
         if (!mode[0]) begin
            mosi = din[BW-1-i];
            wait_neg(H);
            dout[BW-1-i] = miso;
            sclk = ~sclk;
            wait_neg(H);
            sclk = ~sclk;
         end else begin
            sclk = ~sclk;
            mosi = din[BW-1-i];
            wait_neg(H);
            dout[BW-1-i] = miso;
            sclk = ~sclk;
            wait_neg(H);
         end
      end
      if (end_frame) begin
         wait_neg(H);
         cs   = 1'b1;
         mosi = 1'b0;
         wait_neg(2 * H);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      wait_neg(3);
      checks++; if (miso !== 1'b0)      begin errors++; $display("FAIL rst_miso: got %b required 0", miso); end
      checks++; if (send_val !== 1'b0)  begin errors++; $display("FAIL rst_send_val: got %b required 0", send_val); end
      checks++; if (send_msg !== '0)    begin errors++; $display("FAIL rst_send_msg: got %h required 0", send_msg); end
      checks++; if (parity !== 1'b0)    begin errors++; $display("FAIL rst_parity: got %b required 0", parity); end
      checks++; if ({frame_err, overflow, underrun} !== 3'b000)
         begin errors++; $display("FAIL rst_flags: got %b required 000", {frame_err, overflow, underrun}); end
      checks++; if (recv_rdy !== 1'b0)  begin errors++; $display("FAIL rst_recv_rdy: got %b required 0", recv_rdy); end
      reset = 1'b1;
      wait_neg(1);
      checks++; if (recv_rdy !== 1'b1)  begin errors++; $display("FAIL rst_release_rdy: got %b required 1", recv_rdy); end
   endtask

   task automatic test_modes();
      logic [BW-1:0] rx;
      int fe0, ov0, ur0, sv0;
      send_rdy = 1'b1;
      for (int m = 0; m < 4; m++) begin
         fe0 = fe_cnt; ov0 = ov_cnt; ur0 = ur_cnt; sv0 = sv_cnt;
         load_tx(32'hA5A5_0F0F);
         spi_frame(m[1:0], BW, 32'h1234_5678, 1'b1, rx);
         checks++; if (rx !== 32'hA5A5_0F0F)
            begin errors++; $display("FAIL mode%0d_miso: got %h required a5a50f0f", m, rx); end
         checks++; if (sv_cnt - sv0 !== 1)
            begin errors++; $display("FAIL mode%0d_send_val_cycles: got %0d required 1", m, sv_cnt - sv0); end
         checks++; if (last_msg !== 32'h1234_5678)
            begin errors++; $display("FAIL mode%0d_send_msg: got %h required 12345678", m, last_msg); end
         // 0x12345678 has 13 set bits, all within [28:0].
         checks++; if (last_par !== 1'b1)
            begin errors++; $display("FAIL mode%0d_parity: got %b required 1", m, last_par); end
         checks++; if ((fe_cnt - fe0) + (ov_cnt - ov0) + (ur_cnt - ur0) !== 0)
            begin errors++; $display("FAIL mode%0d_flags: got fe=%0d ov=%0d ur=%0d required 0", m,
                                     fe_cnt - fe0, ov_cnt - ov0, ur_cnt - ur0); end
      end
   endtask

   task automatic test_short_frame();
      logic [BW-1:0] rx;
      int fe0, sv0;
      send_rdy = 1'b1;
      fe0 = fe_cnt; sv0 = sv_cnt;
      load_tx(32'h0000_0000);
      spi_frame(2'b00, 20, 32'hFFFF_FFFF, 1'b1, rx);
      checks++; if (fe_cnt - fe0 !== 1)
         begin errors++; $display("FAIL short_frame_err: got %0d pulses required 1", fe_cnt - fe0); end
      checks++; if (sv_cnt - sv0 !== 0)
         begin errors++; $display("FAIL short_send_val: got %0d cycles required 0", sv_cnt - sv0); end
      fe0 = fe_cnt; sv0 = sv_cnt;
      load_tx(32'h5555_AAAA);
      spi_frame(2'b00, BW, 32'hDEAD_BEEF, 1'b1, rx);
      checks++; if (last_msg !== 32'hDEAD_BEEF)
         begin errors++; $display("FAIL after_short_msg: got %h required deadbeef", last_msg); end
      checks++; if (rx !== 32'h5555_AAAA)
         begin errors++; $display("FAIL after_short_miso: got %h required 5555aaaa", rx); end
      checks++; if (fe_cnt - fe0 !== 0 || sv_cnt - sv0 !== 1)
         begin errors++; $display("FAIL after_short_pulses: got fe=%0d sv=%0d required 0/1", fe_cnt - fe0, sv_cnt - sv0); end
   endtask

   task automatic test_overflow();
      logic [BW-1:0] rx;
      int ov0;
      send_rdy = 1'b0;
      ov0 = ov_cnt;
      load_tx(32'h0);
      spi_frame(2'b00, BW, 32'h1111_1111, 1'b1, rx);
      load_tx(32'h0);
      spi_frame(2'b00, BW, 32'h2222_2222, 1'b1, rx);
      checks++; if (ov_cnt - ov0 !== 1)
         begin errors++; $display("FAIL overflow_pulse: got %0d required 1", ov_cnt - ov0); end
      checks++; if (send_val !== 1'b1)
         begin errors++; $display("FAIL overflow_send_val: got %b required 1", send_val); end
      checks++; if (send_msg !== 32'h1111_1111)
         begin errors++; $display("FAIL overflow_held_msg: got %h required 11111111", send_msg); end
      // 0x11111111 has 8 set bits, all within [28:0].
      checks++; if (parity !== 1'b0)
         begin errors++; $display("FAIL overflow_parity: got %b required 0", parity); end
      send_rdy = 1'b1;
      wait_neg(1);
      checks++; if (send_val !== 1'b0)
         begin errors++; $display("FAIL handshake_drop: got send_val=%b required 0", send_val); end
   endtask

   task automatic test_underrun();
      logic [BW-1:0] rx;
      int ur0;
      send_rdy = 1'b1;
      ur0 = ur_cnt;
      spi_frame(2'b00, BW, 32'h0F0F_1234, 1'b1, rx);
      checks++; if (ur_cnt - ur0 !== 1)
         begin errors++; $display("FAIL underrun_pulse: got %0d required 1", ur_cnt - ur0); end
      checks++; if (rx !== 32'h0)
         begin errors++; $display("FAIL underrun_miso: got %h required 0", rx); end
      checks++; if (last_msg !== 32'h0F0F_1234)
         begin errors++; $display("FAIL underrun_rx_msg: got %h required 0f0f1234", last_msg); end
      load_tx(32'h0000_0001);
      checks++; if (recv_rdy !== 1'b0)
         begin errors++; $display("FAIL underrun_accept: recv_rdy=%b required 0 after handshake", recv_rdy); end
   endtask

   task automatic test_reset_mid_frame();
      logic [BW-1:0] rx;
      int fe0, ov0, ur0, sv0;
      spi_frame(2'b00, 10, 32'hCAFE_F00D, 1'b0, rx);
      fe0 = fe_cnt; ov0 = ov_cnt; ur0 = ur_cnt;
      reset = 1'b0;
      cs    = 1'b1;
      sclk  = 1'b0;
      mosi  = 1'b0;
      wait_neg(2);
      checks++; if (miso !== 1'b0 || recv_rdy !== 1'b0 || send_val !== 1'b0)
         begin errors++; $display("FAIL midrst_ctrl: got miso=%b rdy=%b val=%b required 0/0/0", miso, recv_rdy, send_val); end
      checks++; if (send_msg !== '0)
         begin errors++; $display("FAIL midrst_send_msg: got %h required 0", send_msg); end
      wait_neg(H);
      reset = 1'b1;
      wait_neg(1);
      sv0 = sv_cnt;
      load_tx(32'h5A5A_C3C3);
      spi_frame(2'b00, BW, 32'hCAFE_F00D, 1'b1, rx);
      checks++; if (last_msg !== 32'hCAFE_F00D || sv_cnt - sv0 !== 1)
         begin errors++; $display("FAIL midrst_frame_msg: got %h (%0d cycles) required cafef00d (1)", last_msg, sv_cnt - sv0); end
      checks++; if (rx !== 32'h5A5A_C3C3)
         begin errors++; $display("FAIL midrst_frame_miso: got %h required 5a5ac3c3", rx); end
      checks++; if ((fe_cnt - fe0) + (ov_cnt - ov0) + (ur_cnt - ur0) !== 0)
         begin errors++; $display("FAIL midrst_flags: got fe=%0d ov=%0d ur=%0d required 0",
                                  fe_cnt - fe0, ov_cnt - ov0, ur_cnt - ur0); end
   endtask

   initial begin
      test_reset();
      test_modes();
      test_short_frame();
      test_overflow();
      test_underrun();
      test_reset_mid_frame();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/spi_minion_mode.md
Name: spi_minion_mode

Overview:
- Parametrised successor to the existing SPI minion. Handles all four SPI modes (CPOL/CPHA latched per frame), any byte-aligned BIT_WIDTH and a configurable synchroniser depth.
- Adds a one-entry transmit buffer, frame-length error detection, receive overflow and transmit underrun flags, plus parity over the received word.
- Sits between the external SPI pins and the internal val/rdy fabric.

Parameters:
- BIT_WIDTH, 32, frame length in bits. Must be a multiple of 8 and ≥8; elaboration error otherwise.
- SYNC_STAGES, 2, flop depth of the cs/sclk/mosi synchronisers (≥2).
- PARITY_WIDTH, BIT_WIDTH-3, number of low bits of the received word covered by parity.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- cs  in  1  chip select, active low, asynchronous to clk
- sclk  in  1  SPI clock, asynchronous to clk
- mosi  in  1  serial data in
- miso  out  1  serial data out
- cpol  in  1  clock polarity; sampled at frame start
- cpha  in  1  clock phase; sampled at frame start
- recv_msg  in  BIT_WIDTH  word to transmit on miso
- recv_val  in  1  recv_msg valid
- recv_rdy  out  1  transmit buffer can accept
- send_msg  out  BIT_WIDTH  word received from mosi
- send_val  out  1  send_msg valid
- send_rdy  in  1  consumer accepts send_msg
- parity  out  1  XOR of send_msg[PARITY_WIDTH-1:0], ANDed with send_val
- frame_err  out  1  one-cycle pulse: frame ended with wrong bit count
- overflow  out  1  one-cycle pulse: complete frame dropped, send_val still high
- underrun  out  1  one-cycle pulse: frame started with empty transmit buffer

Behaviour:
- Reset (reset=0 at posedge clk):
  - Outputs: miso=0, send_val=0, send_msg=0, parity=0, frame_err=0, overflow=0, underrun=0, recv_rdy=0.
  - Internal: tx buffer empty, bit counter 0, state IDLE, synchroniser flops set to cs=1, sclk=0, mosi=0.
  - The cycle after reset releases, recv_rdy=1.
- Synchronisation and edge detection:
  - cs, sclk and mosi each pass through SYNC_STAGES flops.
  - Edges are detected by comparing the last two synchronised samples.
  - Requirement on sclk: high and low phases each ≥ SYNC_STAGES+2 clk cycles.
- States:
  - IDLE: on synchronised cs fall → ACTIVE. In that same cycle:
    - latch cpol/cpha into mode regs;
    - move the tx buffer into the tx shift register (buffer becomes empty);
    - if the buffer was empty, load zeros and pulse underrun;
    - clear the bit counter.
  - ACTIVE:
    - Leading edge = sclk rise if cpol=0, else fall. Trailing edge = the opposite.
    - Sample edge = leading if cpha=0, else trailing. Shift edge = the other one.
    - On each sample edge with count<BIT_WIDTH: rx_shift <= {rx_shift[BIT_WIDTH-2:0], mosi_sync}, count++. Sample edges at count==BIT_WIDTH are ignored and mark the frame as over-length.
    - On each shift edge: tx_shift shifts left. For cpha=1, the first shift edge is suppressed.
    - miso = tx_shift[BIT_WIDTH-1] (registered; MSB first).
    - On synchronised cs rise → IDLE.
  - Frame end (cs rise), in the same cycle:
    - count==BIT_WIDTH and not over-length:
      - send_val=0 → send_msg <= rx_shift, send_val <= 1;
      - send_val=1 and send_rdy=0 → overflow pulse, new word dropped, held word unchanged;
      - send_val=1 and send_rdy=1 → new word replaces the old one, send_val stays 1, no overflow.
    - Otherwise → frame_err pulse, word discarded, send_* unchanged.
- Handshakes:
  - recv_rdy = (state==IDLE) && tx buffer empty.
  - A recv_val&&recv_rdy transfer in the same cycle as cs fall loads the buffer for the next frame, not the current one; the current frame underruns.
  - send_val stays high until send_rdy; it falls the cycle after handshake.
  - No combinational paths from inputs to outputs.
- Parity is combinational from the send_msg register and is 0 whenever send_val=0.
- miso returns to 0 in IDLE.
- cpol/cpha changes during ACTIVE are ignored.
- A reset during ACTIVE aborts the frame with no flags raised.

Decomposition:
- Shared package spi_pkg:
  - typedef spi_state_t {IDLE, ACTIVE};
  - typedef spi_mode_t {cpol, cpha} packed struct;
  - function sample_edge(mode, rise, fall);
  - localparam default SYNC_STAGES.
- One sub-module, spi_sync_edge: parametrised SYNC_STAGES synchroniser plus rise/fall detector. Instantiate three times (cs, sclk, mosi; mosi ignores edge outputs).

Test Plan:
- BIT_WIDTH=32, mode 0:
  - Preload recv_msg=0xA5A5_0F0F, drive mosi 0x1234_5678 MSB first, send_rdy=1 → send_msg=0x1234_5678 for one cycle.
  - miso bit sequence equals 0xA5A5_0F0F.
  - parity=^0x1234_5678[28:0].
- Repeat with modes 1, 2 and 3, same data → identical send_msg and miso sequence in each mode; no flags.
- Short frame: cs rises after 20 sclk cycles → frame_err pulses once; send_val stays 0; next full frame of 0xDEAD_BEEF is received correctly.
- Overflow: send_rdy=0, two back-to-back frames 0x1111_1111 then 0x2222_2222 → overflow pulses at the second cs rise; send_msg stays 0x1111_1111.
- Underrun: no recv_val before cs fall → underrun pulses; miso stays 0 for all 32 bits; recv handshake is accepted after cs rise.
- Reset mid-frame: reset=0 after 10 bits, release, then full frame 0xCAFE_F00D → outputs are at reset values during reset; the following frame is correct with no flags.
